mem_wb_stage: RTL
=================

// Module: mem_wb_stage
// PURPOSE
//  MEM/WB pipeline register and writeback logic for the 5-stage MIPS core; drives the register file's write port.
//  Captures the MEM-stage result, aligns and extends load data, selects the writeback source (ALU / load / link PC),
//  suppresses writes to $zero, and exports WB-stage forwarding info plus a retired-instruction counter.
// PARAMETERS
//  DATA_W   32  datapath width (only 32 supported)
//  CNT_W    32  retired-instruction counter width
// PORTS
//  clk            in   1   single clock, all state on posedge
//  rst            in   1   synchronous, active-high reset
//  mem_valid      in   1   MEM stage holds a real instruction
//  mem_alu_result in   32  ALU result / effective address
//  mem_rdata      in   32  raw word from data memory (big-endian word)
//  mem_pc_plus4   in   32  PC+4 of the instruction (link value is PC+8 = mem_pc_plus4+4)
//  mem_rd         in   5   destination register index
//  mem_reg_write  in   1   instruction writes a GPR
//  mem_wb_sel     in   2   0=ALU, 1=load, 2=link, 3=reserved (treated as ALU)
//  mem_load_type  in   3   LW=0 LH=1 LHU=2 LB=3 LBU=4, others=LW
//  stall          in   1   hold MEM/WB contents this cycle
//  flush          in   1   kill incoming instruction (bubble)
//  write_reg      out  5   to regfile write_reg
//  write_data     out  32  to regfile write_data
//  RegWrite       out  1   to regfile RegWrite
//  wb_fwd_valid   out  1   WB holds a pending write usable by the forwarding unit
//  addr_err       out  1   misaligned load in WB (one pulse per instruction)
//  retired        out  CNT_W count of instructions retired
// BEHAVIOUR
//  - Reset: all pipeline fields cleared, valid=0, consumed=0, retired=0; outputs write_reg=0, write_data=0,
//    RegWrite=0, wb_fwd_valid=0, addr_err=0.
//  - Capture: on posedge, if rst -> reset; else if flush -> valid<=0, consumed<=0 (flush beats stall);
//    else if stall -> hold all fields, consumed<=1 when valid; else load all mem_* fields, valid<=mem_valid, consumed<=0.
//  - Latency: instruction at MEM inputs at edge N appears on WB outputs in cycle N..N+1; regfile writes at edge N+1.
//  - Outputs combinational from registered fields only (no input->output comb path).
//  - RegWrite = valid & reg_write & (rd!=0) & ~consumed & ~misaligned. A stalled entry writes exactly once.
//  - wb_fwd_valid = valid & reg_write & (rd!=0) & ~misaligned (stays high while held by stall).
//  - Load alignment, off = alu_result[1:0], big-endian (byte 0 = rdata[31:24]):
//    LW: rdata; LH/LHU: off0 -> [31:16], off2 -> [15:0], sign/zero extend; LB/LBU: byte off, sign/zero extend.
//  - Misaligned: LW with off!=0, LH/LHU with off[0]=1 (only when wb_sel=load) -> addr_err=1 for first cycle,
//    write suppressed; retired still increments.
//  - write_data: sel ALU -> alu_result; load -> aligned data; link -> pc_plus4+4 (32-bit wrap).
//  - retired increments by 1 on each cycle where valid & ~consumed; wraps modulo 2^CNT_W.
//  - Reset mid-stall clears entry; no write issued for it.
// STRUCTURE
//  - mips_pkg: WB_SEL_* and LD_* encodings, DATA_W.
//  - Sub-module load_align (combinational: rdata, off, load_type -> data, misaligned); top holds register + counter.
// TESTING
//  - Reset: rst=1 two cycles -> RegWrite=0, retired=0, wb_fwd_valid=0.
//  - ALU write: rd=5, alu=0x0000_1234, sel=0 -> next cycle write_reg=5, write_data=0x1234, RegWrite=1; retired=1.
//  - Loads: rdata=0x80FF_7F01; LB off1 -> 0xFFFF_FFFF; LBU off0 -> 0x0000_0080; LH off2 -> 0x0000_7F01; LHU off0 -> 0x0000_80FF.
//  - $zero/misaligned: rd=0 -> RegWrite=0; LW alu=0x...02 -> addr_err=1 one cycle, RegWrite=0, retired still +1.
//  - Stall 3 cycles on rd=7 link, pc_plus4=0x0040_0008 -> write_data=0x0040_000C, RegWrite=1 only first cycle,
//    wb_fwd_valid=1 all cycles, retired +1 once.
//  - Stall+flush same cycle -> flush wins, valid=0; counter at 0xFFFF_FFFF + retire -> 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings and the MEM/WB entry layout for the 5-stage MIPS core.
package mips_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_LOAD = 2'd1;
    localparam logic [1:0] WB_SEL_LINK = 2'd2;
    localparam logic [1:0] WB_SEL_RSVD = 2'd3;

    localparam logic [2:0] LD_LW  = 3'd0;
    localparam logic [2:0] LD_LH  = 3'd1;
    localparam logic [2:0] LD_LHU = 3'd2;
    localparam logic [2:0] LD_LB  = 3'd3;
    localparam logic [2:0] LD_LBU = 3'd4;

    typedef struct packed {
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] rdata;
        logic [DATA_W-1:0] pc_plus4;
        logic [4:0]        rd;
        logic              reg_write;
        logic [1:0]        wb_sel;
        logic [2:0]        load_type;
    } mem_wb_t;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Big-endian load alignment: picks the addressed byte/halfword, extends it,
// and flags addresses that are misaligned for the access size.
module load_align
    import mips_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  load_type_i,
    output logic [31:0] data_o,
    output logic        misaligned_o
);

    function automatic logic [31:0] sext8(input logic [7:0] b);
        logic signed [7:0]  s;
        logic signed [31:0] w;
        s = b;
        w = s;
        return w;
    endfunction

    function automatic logic [31:0] sext16(input logic [15:0] h);
        logic signed [15:0] s;
        logic signed [31:0] w;
        s = h;
        w = s;
        return w;
    endfunction

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Byte 0 lives in the most significant lane.
    always_comb begin
        byte_sel = rdata_i[31:24];
        case (off_i)
            2'd0: byte_sel = rdata_i[31:24];
            2'd1: byte_sel = rdata_i[23:16];
            2'd2: byte_sel = rdata_i[15:8];
            2'd3: byte_sel = rdata_i[7:0];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = off_i[1] ? rdata_i[15:0] : rdata_i[31:16];
    end

    always_comb begin
        data_o       = rdata_i;
        misaligned_o = (off_i != 2'd0);
        case (load_type_i)
            LD_LH: begin
                data_o       = sext16(half_sel);
                misaligned_o = off_i[0];
            end
            LD_LHU: begin
                data_o       = {16'h0000, half_sel};
                misaligned_o = off_i[0];
            end
            LD_LB: begin
                data_o       = sext8(byte_sel);
                misaligned_o = 1'b0;
            end
            LD_LBU: begin
                data_o       = {24'h000000, byte_sel};
                misaligned_o = 1'b0;
            end
            default: begin
                data_o       = rdata_i;
                misaligned_o = (off_i != 2'd0);
            end
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback: source select, $zero suppression,
// single-shot write under stall, forwarding info and retired-instruction count.
module mem_wb_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_alu_result,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [DATA_W-1:0] mem_pc_plus4,
    input  logic [4:0]        mem_rd,
    input  logic              mem_reg_write,
    input  logic [1:0]        mem_wb_sel,
    input  logic [2:0]        mem_load_type,
    input  logic              stall,
    input  logic              flush,
    output logic [4:0]        write_reg,
    output logic [DATA_W-1:0] write_data,
    output logic              RegWrite,
    output logic              wb_fwd_valid,
    output logic              addr_err,
    output logic [CNT_W-1:0]  retired
);
    import mips_pkg::*;

    mem_wb_t          entry_q, entry_d;
    logic             valid_q, valid_d;
    logic             consumed_q, consumed_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire;

    // consumed marks an entry whose write already went out while held by stall.
    always_comb begin
        entry_d    = entry_q;
        valid_d    = valid_q;
        consumed_d = consumed_q;
        if (flush) begin
            valid_d    = 1'b0;
            consumed_d = 1'b0;
        end else if (stall) begin
            if (valid_q) consumed_d = 1'b1;
        end else begin
            entry_d.alu_result = mem_alu_result;
            entry_d.rdata      = mem_rdata;
            entry_d.pc_plus4   = mem_pc_plus4;
            entry_d.rd         = mem_rd;
            entry_d.reg_write  = mem_reg_write;
            entry_d.wb_sel     = mem_wb_sel;
            entry_d.load_type  = mem_load_type;
            valid_d            = mem_valid;
            consumed_d         = 1'b0;
        end
        retire    = valid_q & ~consumed_q;
        retired_d = retired_q + {{(CNT_W-1){1'b0}}, retire};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entry_q    <= '0;
            valid_q    <= 1'b0;
            consumed_q <= 1'b0;
            retired_q  <= '0;
        end else begin
            entry_q    <= entry_d;
            valid_q    <= valid_d;
            consumed_q <= consumed_d;
            retired_q  <= retired_d;
        end
    end

    logic [31:0] load_data;
    logic        load_mis;
    logic        misaligned;
    logic        writes_gpr;

    load_align u_load_align (
        .rdata_i      (entry_q.rdata),
        .off_i        (entry_q.alu_result[1:0]),
        .load_type_i  (entry_q.load_type),
        .data_o       (load_data),
        .misaligned_o (load_mis)
    );

    always_comb begin
        misaligned = (entry_q.wb_sel == WB_SEL_LOAD) & load_mis;
        writes_gpr = valid_q & entry_q.reg_write & (entry_q.rd != 5'd0) & ~misaligned;
        case (entry_q.wb_sel)
            WB_SEL_LOAD: write_data = load_data;
            WB_SEL_LINK: write_data = entry_q.pc_plus4 + 32'd4;
            default:     write_data = entry_q.alu_result;
        endcase
        write_reg    = entry_q.rd;
        RegWrite     = writes_gpr & ~consumed_q;
        wb_fwd_valid = writes_gpr;
        addr_err     = valid_q & misaligned & ~consumed_q;
        retired      = retired_q;
    end

endmodule
